// File: rtl/best_1ofn_pipe.sv
// Pipelined 1-of-N best-candidate selector: binary tournament over NCH channels,
// one register per tree level, then a final stage that clamps the quarter-strip sub-key.
module best_1ofn_pipe #(
  parameter int NCH   = 7,
  parameter int PATB  = 7,
  parameter int KEYB  = 5,
  parameter int OFFSB = 4,
  parameter int QLTB  = 6,
  parameter int BNDB  = 5,
  parameter int CARB  = 11,
  parameter int SORTQ = 0,
  parameter int SPLIT = 128
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_vld,
  input  logic [NCH*PATB-1:0]             pat,
  input  logic [NCH*KEYB-1:0]             key,
  input  logic [NCH*OFFSB-1:0]            offs,
  input  logic [NCH*QLTB-1:0]             qlt,
  input  logic [NCH*BNDB-1:0]             bend,
  input  logic [NCH*CARB-1:0]             carry,
  output logic                            out_vld,
  output logic [PATB-1:0]                 best_pat,
  output logic [$clog2(NCH)+KEYB-1:0]     best_key,
  output logic [QLTB-1:0]                 best_qlt,
  output logic [BNDB-1:0]                 best_bend,
  output logic [CARB-1:0]                 best_carry,
  output logic [$clog2(NCH)+KEYB+1:0]     best_subkey,
  output logic                            best_any
);

  localparam int CHB   = $clog2(NCH);
  localparam int KEYBX = CHB + KEYB;
  localparam int SUBB  = KEYBX + 2;
  localparam int L     = $clog2(NCH);
  localparam int SW    = (QLTB > PATB - 1) ? QLTB : PATB - 1;
  localparam int KMAX  = NCH * (1 << KEYB) - 1;

  // Number of candidates entering tree level l.
  function automatic int unsigned lvl_cnt(input int unsigned l);
    int unsigned r;
    r = NCH;
    for (int unsigned i = 0; i < l; i++) r = (r + 1) / 2;
    return r;
  endfunction

  // Offset of level l (l >= 1) inside the flat register array tree_q.
  function automatic int unsigned tq_off(input int unsigned l);
    int unsigned r;
    r = 0;
    for (int unsigned m = 1; m < l; m++) r += lvl_cnt(m);
    return r;
  endfunction

  localparam int unsigned TQN = tq_off(L + 1);

  typedef struct packed {
    logic [SW-1:0]    sort;
    logic [PATB-1:0]  pat;
    logic [KEYB-1:0]  key;
    logic [CHB-1:0]   ch;
    logic [OFFSB-1:0] offs;
    logic [QLTB-1:0]  qlt;
    logic [BNDB-1:0]  bend;
    logic [CARB-1:0]  carry;
  } rec_t;

  rec_t       in_rec [NCH];
  rec_t       tree_q [TQN];
  logic [L-1:0] vld_q;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      in_rec[i].pat   = pat[i*PATB +: PATB];
      in_rec[i].key   = key[i*KEYB +: KEYB];
      in_rec[i].ch    = CHB'(i);
      in_rec[i].offs  = offs[i*OFFSB +: OFFSB];
      in_rec[i].qlt   = qlt[i*QLTB +: QLTB];
      in_rec[i].bend  = bend[i*BNDB +: BNDB];
      in_rec[i].carry = carry[i*CARB +: CARB];
      if (SORTQ != 0) in_rec[i].sort = SW'(qlt[i*QLTB +: QLTB]);
      else            in_rec[i].sort = SW'(pat[i*PATB+1 +: PATB-1]);
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int unsigned NI = lvl_cnt(l);
    localparam int unsigned NO = lvl_cnt(l + 1);
    rec_t src [NI];

    for (genvar k = 0; k < NI; k++) begin : g_src
      if (l == 0) begin : g_in
        assign src[k] = in_rec[k];
      end else begin : g_tree
        assign src[k] = tree_q[tq_off(l) + k];
      end
    end

    // Left operand always holds the lower channel indices, so "strictly greater"
    // on the right resolves ties toward the lower channel.
    for (genvar j = 0; j < NO; j++) begin : g_node
      localparam int unsigned DI = tq_off(l + 1) + j;
      if (2 * j + 1 < NI) begin : g_cmp
        always_ff @(posedge clock)
          tree_q[DI] <= (src[2*j+1].sort > src[2*j].sort) ? src[2*j+1] : src[2*j];
      end else begin : g_pass
        always_ff @(posedge clock)
          tree_q[DI] <= src[2*j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) vld_q <= '0;
    else       vld_q <= (vld_q << 1) | L'(in_vld);
  end

  rec_t                   win;
  logic [KEYBX-1:0]       win_key;
  logic signed [SUBB+1:0] s, lo4, hi4;
  logic [SUBB-1:0]        sub;

  assign win     = tree_q[TQN-1];
  assign win_key = {win.ch, win.key};

  // Clamp against the winner's own segment so an offset can never push the
  // sub-key into the neighbouring half.
  always_comb begin
    s   = $signed({2'b00, win_key, 2'b00})
        + $signed({{(SUBB+2-OFFSB){win.offs[OFFSB-1]}}, win.offs});
    lo4 = '0;
    hi4 = (SUBB+2)'(4 * KMAX);
    if (SPLIT != 0) begin
      if (int'(win_key) < SPLIT) hi4 = (SUBB+2)'(4 * (SPLIT - 1));
      else                       lo4 = (SUBB+2)'(4 * SPLIT);
    end
    if (s < lo4)      sub = lo4[SUBB-1:0];
    else if (s > hi4) sub = hi4[SUBB-1:0];
    else              sub = s[SUBB-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_vld     <= 1'b0;
      best_pat    <= '0;
      best_key    <= '0;
      best_qlt    <= '0;
      best_bend   <= '0;
      best_carry  <= '0;
      best_subkey <= '0;
      best_any    <= 1'b0;
    end else begin
      out_vld <= vld_q[L-1];
      if (vld_q[L-1]) begin
        best_pat    <= win.pat;
        best_key    <= win_key;
        best_qlt    <= win.qlt;
        best_bend   <= win.bend;
        best_carry  <= win.carry;
        best_subkey <= sub;
        best_any    <= (win.sort != '0);
      end
    end
  end

endmodule

// File: tb/tb_best_1ofn_pipe.sv
// Directed self-checking bench for best_1ofn_pipe at default parameters (NCH=7, SORTQ=0, SPLIT=128).
module tb_best_1ofn_pipe;

  localparam int NCH = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_vld;
  logic [48:0]   pat;
  logic [34:0]   key;
  logic [27:0]   offs;
  logic [41:0]   qlt;
  logic [34:0]   bend;
  logic [76:0]   carry;
  logic          out_vld;
  logic [6:0]    best_pat;
  logic [7:0]    best_key;
  logic [5:0]    best_qlt;
  logic [4:0]    best_bend;
  logic [10:0]   best_carry;
  logic [9:0]    best_subkey;
  logic          best_any;

  logic [6:0]  p_a [NCH];
  logic [4:0]  k_a [NCH];
  logic [3:0]  o_a [NCH];
  logic [5:0]  q_a [NCH];
  logic [4:0]  b_a [NCH];
  logic [10:0] c_a [NCH];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  best_1ofn_pipe dut (
    .clock(clock), .reset(reset), .in_vld(in_vld),
    .pat(pat), .key(key), .offs(offs), .qlt(qlt), .bend(bend), .carry(carry),
    .out_vld(out_vld), .best_pat(best_pat), .best_key(best_key), .best_qlt(best_qlt),
    .best_bend(best_bend), .best_carry(best_carry), .best_subkey(best_subkey),
    .best_any(best_any)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_ch();
    for (int i = 0; i < NCH; i++) begin
      p_a[i] = '0;
      k_a[i] = '0;
      o_a[i] = '0;
      q_a[i] = 6'(i * 5 + 1);
      b_a[i] = 5'(i + 3);
      c_a[i] = 11'(100 * i + 7);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NCH; i++) begin
      pat[i*7 +: 7]    = p_a[i];
      key[i*5 +: 5]    = k_a[i];
      offs[i*4 +: 4]   = o_a[i];
      qlt[i*6 +: 6]    = q_a[i];
      bend[i*5 +: 5]   = b_a[i];
      carry[i*11 +: 11] = c_a[i];
    end
  endtask

  // One beat, then wait (bounded) for out_vld; lat counts edges including the input edge.
  task automatic send_wait(output int lat);
    apply();
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    lat = 1;
    while (out_vld !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int got;
    int vcount;
    int q_key[$];
    int q_pat[$];
    int q_cyc[$];

    reset  = 1'b1;
    in_vld = 1'b0;
    clear_ch();
    apply();
    step();
    step();
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_key", 32'(best_key), 32'd0);
    check("rst_pat", 32'(best_pat), 32'd0);
    check("rst_sub", 32'(best_subkey), 32'd0);
    check("rst_any", 32'(best_any), 32'd0);
    reset = 1'b0;
    step();

    // All equal sort fields: lowest channel wins.
    clear_ch();
    for (int i = 0; i < NCH; i++) begin
      p_a[i] = 7'd10;
      k_a[i] = 5'(i + 1);
    end
    send_wait(lat);
    check("tie_lat", 32'(lat), 32'd4);
    check("tie_key", 32'(best_key), 32'd1);
    check("tie_any", 32'(best_any), 32'd1);
    check("tie_pat", 32'(best_pat), 32'd10);
    check("tie_qlt", 32'(best_qlt), 32'd1);
    check("tie_bend", 32'(best_bend), 32'd3);
    check("tie_carry", 32'(best_carry), 32'd7);
    check("tie_sub", 32'(best_subkey), 32'd4);
    step();
    check("hold_vld", 32'(out_vld), 32'd0);
    check("hold_key", 32'(best_key), 32'd1);

    // Bend lsb ignored: 9 and 8 both sort as 4, ch3 beats ch5.
    clear_ch();
    for (int i = 0; i < NCH; i++) p_a[i] = 7'd2;
    p_a[3] = 7'd9; k_a[3] = 5'd5; o_a[3] = 4'd1;
    p_a[5] = 7'd8; k_a[5] = 5'd9;
    send_wait(lat);
    check("lsb_lat", 32'(lat), 32'd4);
    check("lsb_key", 32'(best_key), 32'd101);
    check("lsb_pat", 32'(best_pat), 32'd9);
    check("lsb_qlt", 32'(best_qlt), 32'd16);
    check("lsb_bend", 32'(best_bend), 32'd6);
    check("lsb_carry", 32'(best_carry), 32'd307);
    check("lsb_sub", 32'(best_subkey), 32'd405);

    // Sub-key clamping at segment edges.
    clear_ch(); p_a[0] = 7'd20; o_a[0] = 4'hD;
    send_wait(lat);
    check("sub0_key", 32'(best_key), 32'd0);
    check("sub0_val", 32'(best_subkey), 32'd0);
    clear_ch(); p_a[3] = 7'd20; k_a[3] = 5'd31; o_a[3] = 4'd3;
    send_wait(lat);
    check("sub127_key", 32'(best_key), 32'd127);
    check("sub127_val", 32'(best_subkey), 32'd508);
    clear_ch(); p_a[4] = 7'd20; o_a[4] = 4'hE;
    send_wait(lat);
    check("sub128_key", 32'(best_key), 32'd128);
    check("sub128_val", 32'(best_subkey), 32'd512);
    clear_ch(); p_a[6] = 7'd20; k_a[6] = 5'd31; o_a[6] = 4'd3;
    send_wait(lat);
    check("subtop_key", 32'(best_key), 32'd223);
    check("subtop_val", 32'(best_subkey), 32'd892);
    clear_ch(); p_a[3] = 7'd20; k_a[3] = 5'd31; o_a[3] = 4'h8;
    send_wait(lat);
    check("subneg_val", 32'(best_subkey), 32'd500);

    // All sort fields zero (pat lsb set on ch0/ch2 must not count).
    clear_ch(); p_a[0] = 7'd1; p_a[2] = 7'd1; k_a[0] = 5'd7;
    send_wait(lat);
    check("zero_lat", 32'(lat), 32'd4);
    check("zero_vld", 32'(out_vld), 32'd1);
    check("zero_key", 32'(best_key), 32'd7);
    check("zero_pat", 32'(best_pat), 32'd1);
    check("zero_any", 32'(best_any), 32'd0);
    check("zero_sub", 32'(best_subkey), 32'd28);
    step();

    // Ten back-to-back beats with distinct winners.
    got = 0;
    for (int b = 0; b < 10; b++) begin
      clear_ch();
      p_a[b % NCH] = 7'(2 * b + 4);
      k_a[b % NCH] = 5'(b + 1);
      apply();
      in_vld = 1'b1;
      step();
      q_key.push_back((b % NCH) * 32 + b + 1);
      q_pat.push_back(2 * b + 4);
      q_cyc.push_back(cyc);
      if (out_vld === 1'b1) begin
        check("bb_key", 32'(best_key), 32'(q_key.pop_front()));
        check("bb_pat", 32'(best_pat), 32'(q_pat.pop_front()));
        check("bb_lat", 32'(cyc - q_cyc.pop_front() + 1), 32'd4);
        got++;
      end
    end
    in_vld = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (out_vld === 1'b1) begin
        if (q_key.size() == 0) begin
          check("bb_extra", 32'd1, 32'd0);
        end else begin
          check("bb_key", 32'(best_key), 32'(q_key.pop_front()));
          check("bb_pat", 32'(best_pat), 32'(q_pat.pop_front()));
          check("bb_lat", 32'(cyc - q_cyc.pop_front() + 1), 32'd4);
        end
        got++;
      end
    end
    check("bb_count", 32'(got), 32'd10);
    check("bb_hold_key", 32'(best_key), 32'd74);
    check("bb_hold_pat", 32'(best_pat), 32'd22);

    // Reset with three beats in flight.
    clear_ch(); p_a[1] = 7'd30; k_a[1] = 5'd3;
    apply();
    in_vld = 1'b1;
    step(); step(); step();
    in_vld = 1'b0;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    check("flush_vld", 32'(out_vld), 32'd0);
    check("flush_key", 32'(best_key), 32'd0);
    check("flush_pat", 32'(best_pat), 32'd0);
    check("flush_carry", 32'(best_carry), 32'd0);
    vcount = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (out_vld !== 1'b0) vcount++;
    end
    check("flush_quiet", 32'(vcount), 32'd0);
    check("flush_key2", 32'(best_key), 32'd0);
    clear_ch(); p_a[5] = 7'd40; k_a[5] = 5'd2;
    send_wait(lat);
    check("post_lat", 32'(lat), 32'd4);
    check("post_key", 32'(best_key), 32'd162);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/best_1ofn_pipe.md
BEST_1OFN_PIPE -- requirements
Module: best_1ofn_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NCH, 7, number of candidate channels, 2..16
- PATB, 7, pattern-id width
- KEYB, 5, per-channel key width
- OFFSB, 4, signed quarter-strip offset width
- QLTB, 6, quality width
- BNDB, 5, bend width
- CARB, 11, carry width
- SORTQ, 0, sort field: 0 = pat[PATB-1:1], 1 = qlt
- SPLIT, 128, key boundary for sub-key clamping; 0 = no split
REQ-002 Derived widths SHALL be CHB = clog2(NCH), KEYBX = CHB+KEYB, SUBB = KEYBX+2, L = clog2(NCH).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state rising-edge
- reset  in  1  synchronous, active-high
- in_vld  in  1  input beat valid
- pat  in  NCH*PATB  packed pattern ids, channel i at [i*PATB +: PATB]
- key  in  NCH*KEYB  packed keys
- offs  in  NCH*OFFSB  packed signed offsets
- qlt  in  NCH*QLTB  packed qualities
- bend  in  NCH*BNDB  packed bends
- carry  in  NCH*CARB  packed carry
- out_vld  out  1  result valid
- best_pat  out  PATB  winner pattern
- best_key  out  KEYBX  {winner channel, winner key}
- best_qlt  out  QLTB  winner quality
- best_bend  out  BNDB  winner bend
- best_carry  out  CARB  winner carry
- best_subkey  out  SUBB  clamped quarter-strip key
- best_any  out  1  winner sort field nonzero

Function
REQ-004 Sort field per channel SHALL be qlt when SORTQ=1, else pat[PATB-1:1] (lsb, the bend direction, ignored), zero-extended to a common width.
REQ-005 Selection SHALL be a binary tournament tree of L levels, one register stage per level; odd channel at any level passes through its register unchanged.
REQ-006 Each comparison SHALL choose the higher-index candidate only if its sort field is strictly greater; ties SHALL go to the lower channel index.
REQ-007 Full candidate record (pat, key, channel index, offs, qlt, bend, carry) SHALL travel with its sort field through every stage.
REQ-008 A final register stage SHALL compute sub-key and drive outputs; total latency in_vld -> out_vld SHALL be exactly L+1 cycles (4 for NCH=7).
REQ-009 Pipeline SHALL accept one beat per cycle, no stall; out_vld SHALL be in_vld delayed L+1 cycles.
REQ-010 Stages with valid low SHALL still clock data (don't-care) but outputs SHALL be held at last valid result while out_vld=0.
REQ-011 best_key SHALL equal {channel index, key} of the winner; all-zero sort fields SHALL select channel 0 with best_any=0.
REQ-012 Sub-key: s = 4*best_key + sign-extended offs, computed signed in SUBB+2 bits.
REQ-013 Segment: if SPLIT!=0 and best_key<SPLIT, [lo,hi]=[0,SPLIT-1]; if SPLIT!=0 and best_key>=SPLIT, [lo,hi]=[SPLIT,KMAX]; if SPLIT=0, [0,KMAX]; KMAX = NCH*2^KEYB-1.
REQ-014 best_subkey SHALL be 4*lo if s<4*lo, 4*hi if s>4*hi, else s[SUBB-1:0].
REQ-015 Offset overflow across a segment edge SHALL never produce a sub-key in the neighbouring segment.

Reset
REQ-016 While reset=1 at a clock edge, all valid bits and all outputs SHALL be cleared to 0 on that edge.
REQ-017 Reset mid-stream SHALL flush all in-flight beats; none SHALL emerge after reset deasserts.
REQ-018 First out_vld after reset SHALL come no earlier than L+1 cycles after the first in_vld sampled with reset=0.

Verification
REQ-019 NCH=7, SORTQ=0, pat={10,10,10,10,10,10,10} (ch0..6), in_vld 1 cycle -> 4 cycles later out_vld=1, best_key[7:5]=0 (tie to lowest), best_any=1.
REQ-020 pat ch3=9, ch5=8, others 2 -> winner ch3 (lsb ignored, 9 and 8 both sort as 4, lower index wins); best_pat=9.
REQ-021 Winner key=0 in ch0, offs=-3 -> best_subkey=0; key=127 (ch3 key31), offs=+3 -> 508 (clamped at SPLIT-1); key=128, offs=-2 -> 512.
REQ-022 Back-to-back in_vld for 10 cycles with distinct winners -> 10 consecutive out_vld results in order, latency 4 each.
REQ-023 Assert reset while 3 beats in flight -> out_vld stays 0, outputs 0 until a new beat's latency elapses.
REQ-024 All sort fields 0 -> best_key channel 0, best_any=0, out_vld=1.
